// File: rtl/alu_pkg.sv
// Shared definitions for the parametrised pipelined ALU: opcodes, FSM states
// and the registered status-flag bundle.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_NOR  = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_XNOR = 4'h9;
  localparam logic [3:0] OP_EQ   = 4'hA;
  localparam logic [3:0] OP_GT   = 4'hB;
  localparam logic [3:0] OP_LT   = 4'hC;
  localparam logic [3:0] OP_SHR  = 4'hD;
  localparam logic [3:0] OP_SHL  = 4'hE;
  localparam logic [3:0] OP_DEF  = 4'hF;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    DIV_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic arith;
    logic logic_f;
    logic cmp;
    logic shift;
    logic carry;
    logic zero;
    logic divz;
  } flags_t;

  localparam int FLAG_W = $bits(flags_t);

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring divider: one quotient bit per clock, MSB first.
// done/quotient/remainder are combinational on the final iteration cycle.
module alu_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic [CW-1:0]    iter_cnt;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_sub;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] rem_nx;

  // Shifted partial remainder needs one extra bit before the trial subtract.
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    if (!rem_sub[WIDTH]) begin
      rem_nx = rem_sub[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = rem_shift[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  assign done      = busy && (iter_cnt == CW'(WIDTH - 1));
  assign quotient  = quo_nx;
  assign remainder = rem_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      iter_cnt <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      iter_cnt <= '0;
      quo_q    <= a;
      rem_q    <= '0;
      dvs_q    <= b;
    end else if (busy) begin
      quo_q    <= quo_nx;
      rem_q    <= rem_nx;
      iter_cnt <= iter_cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe_param.sv
// Parametrised ALU execution unit with valid/ready issue, registered results
// and flags; divide is iterative and stalls issue while it runs.
module alu_pipe_param
  import alu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SHW        = $clog2(WIDTH),
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_FUN,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic [WIDTH-1:0] REM_OUT,
  output logic             Arith_Flag,
  output logic             Logic_Flag,
  output logic             CMP_Flag,
  output logic             Shift_Flag,
  output logic             Carry_Flag,
  output logic             Zero_Flag,
  output logic             DivZ_Flag
);

  state_t             state, state_nx;
  logic               accept;
  logic               div_go;
  logic               div_done;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   res;
  logic [WIDTH-1:0]   rem;
  flags_t             fl;
  flags_t             flg_q;
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     dif_w;
  logic [2*WIDTH-1:0] prod_w;
  logic               gt, lt;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  assign sum_w  = {1'b0, A} + {1'b0, B};
  assign dif_w  = {1'b0, A} - {1'b0, B};
  assign prod_w = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
  assign gt     = SIGNED_CMP ? ($signed(A) > $signed(B)) : (A > B);
  assign lt     = SIGNED_CMP ? ($signed(A) < $signed(B)) : (A < B);

  always_comb begin
    res    = '0;
    rem    = '0;
    fl     = '0;
    div_go = 1'b0;
    case (ALU_FUN)
      OP_ADD:  begin res = sum_w[WIDTH-1:0]; fl.arith = 1'b1; fl.carry = sum_w[WIDTH]; end
      OP_SUB:  begin res = dif_w[WIDTH-1:0]; fl.arith = 1'b1; fl.carry = dif_w[WIDTH]; end
      OP_MUL:  begin res = prod_w[WIDTH-1:0]; fl.arith = 1'b1; fl.carry = |prod_w[2*WIDTH-1:WIDTH]; end
      OP_DIV: begin
        fl.arith = 1'b1;
        if (B == '0) begin
          res     = '1;
          rem     = A;
          fl.divz = 1'b1;
        end else begin
          div_go  = 1'b1;
        end
      end
      OP_AND:  begin res = A & B;    fl.logic_f = 1'b1; end
      OP_OR:   begin res = A | B;    fl.logic_f = 1'b1; end
      OP_NAND: begin res = ~(A & B); fl.logic_f = 1'b1; end
      OP_NOR:  begin res = ~(A | B); fl.logic_f = 1'b1; end
      OP_XOR:  begin res = A ^ B;    fl.logic_f = 1'b1; end
      OP_XNOR: begin res = ~(A ^ B); fl.logic_f = 1'b1; end
      OP_EQ:   begin res = (A == B) ? WIDTH'(1) : '0; fl.cmp = 1'b1; end
      OP_GT:   begin res = gt ? WIDTH'(2) : '0;       fl.cmp = 1'b1; end
      OP_LT:   begin res = lt ? WIDTH'(3) : '0;       fl.cmp = 1'b1; end
      OP_SHR:  begin res = A >> B[SHW-1:0]; fl.shift = 1'b1; end
      OP_SHL:  begin res = A << B[SHW-1:0]; fl.shift = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept && div_go) state_nx = DIV_BUSY;
      DIV_BUSY: if (div_done)         state_nx = IDLE;
      default:                        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (CLK),
    .rst       (RST),
    .start     (accept && div_go),
    .a         (A),
    .b         (B),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Divider completion and single-cycle issue are mutually exclusive (in_ready is low while busy).
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid <= 1'b0;
      ALU_OUT   <= '0;
      REM_OUT   <= '0;
      flg_q     <= '0;
    end else if (div_done) begin
      out_valid  <= 1'b1;
      ALU_OUT    <= div_quo;
      REM_OUT    <= div_rem;
      flg_q      <= '0;
      flg_q.arith <= 1'b1;
      flg_q.zero  <= (div_quo == '0);
    end else if (accept && !div_go) begin
      out_valid  <= 1'b1;
      ALU_OUT    <= res;
      REM_OUT    <= rem;
      flg_q      <= fl;
      flg_q.zero <= (res == '0);
    end else begin
      out_valid  <= 1'b0;
    end
  end

  assign Arith_Flag = flg_q.arith;
  assign Logic_Flag = flg_q.logic_f;
  assign CMP_Flag   = flg_q.cmp;
  assign Shift_Flag = flg_q.shift;
  assign Carry_Flag = flg_q.carry;
  assign Zero_Flag  = flg_q.zero;
  assign DivZ_Flag  = flg_q.divz;

endmodule

// File: tb/tb_alu_pipe_param.sv
// Directed-vector bench for alu_pipe_param (WIDTH=16, signed compares).
module tb_alu_pipe_param;
  import alu_pkg::*;

  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RST;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A, B;
  logic [3:0]   ALU_FUN;
  logic         out_valid;
  logic [W-1:0] ALU_OUT, REM_OUT;
  logic         Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
  logic         Carry_Flag, Zero_Flag, DivZ_Flag;

  int n_vec = 0;
  int n_err = 0;

  alu_pipe_param #(.WIDTH(W), .SIGNED_CMP(1'b1)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .ALU_FUN    (ALU_FUN),
    .out_valid  (out_valid),
    .ALU_OUT    (ALU_OUT),
    .REM_OUT    (REM_OUT),
    .Arith_Flag (Arith_Flag),
    .Logic_Flag (Logic_Flag),
    .CMP_Flag   (CMP_Flag),
    .Shift_Flag (Shift_Flag),
    .Carry_Flag (Carry_Flag),
    .Zero_Flag  (Zero_Flag),
    .DivZ_Flag  (DivZ_Flag)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flag order: arith logic cmp shift carry zero divz
  function automatic logic [6:0] flags_now();
    return {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag, Carry_Flag, Zero_Flag, DivZ_Flag};
  endfunction

  task automatic expect_out(input string tag, input logic [W-1:0] res,
                            input logic [W-1:0] rem, input logic [6:0] fl);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_res"},   32'(ALU_OUT), 32'(res));
    chk({tag, "_rem"},   32'(REM_OUT), 32'(rem));
    chk({tag, "_flags"}, 32'(flags_now()), 32'(fl));
  endtask

  // Called at a negedge; returns at the next negedge, after the accept edge.
  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    ALU_FUN  = op;
    A        = a;
    B        = b;
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int j, low, cnt;
    RST = 1'b1; in_valid = 1'b0; A = '0; B = '0; ALU_FUN = OP_ADD;
    repeat (2) @(negedge CLK);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_res",   32'(ALU_OUT), 32'd0);
    chk("rst_flags", 32'(flags_now()), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // 1: basic add
    drive(OP_ADD, 16'h0003, 16'h000D);
    expect_out("add1", 16'h0010, 16'h0000, 7'b1000000);

    // 2: back-to-back carry/borrow/mul overflow
    drive(OP_ADD, 16'hFFFF, 16'h0001);
    expect_out("add_carry", 16'h0000, 16'h0000, 7'b1000110);
    drive(OP_MUL, 16'h0100, 16'h0100);
    expect_out("mul_ovf", 16'h0000, 16'h0000, 7'b1000110);
    drive(OP_SUB, 16'h0002, 16'h0003);
    expect_out("sub_borrow", 16'hFFFF, 16'h0000, 7'b1000100);
    in_valid = 1'b0;
    @(negedge CLK);
    chk("hold_valid", 32'(out_valid), 32'd0);
    chk("hold_res",   32'(ALU_OUT), 32'hFFFF);

    // 3: divide with an ADD held on in_valid throughout busy
    drive(OP_DIV, 16'd100, 16'd7);
    ALU_FUN = OP_ADD; A = 16'd1; B = 16'd1;
    j = 0; low = 0;
    while (j < 40 && !out_valid) begin
      if (!in_ready) low++;
      j++;
      @(negedge CLK);
    end
    in_valid = 1'b0;
    chk("div_latency",   32'(j), 32'd16);
    chk("div_ready_low", 32'(low), 32'd16);
    expect_out("div", 16'd14, 16'd2, 7'b1000000);
    @(negedge CLK);
    chk("div_pulse", 32'(out_valid), 32'd0);
    chk("div_hold",  32'(ALU_OUT), 32'd14);

    // 4: divide by zero
    drive(OP_DIV, 16'h1234, 16'h0000);
    expect_out("divz", 16'hFFFF, 16'h1234, 7'b1000001);
    in_valid = 1'b0;

    // 5: reset abandons an in-flight divide
    drive(OP_DIV, 16'd100, 16'd7);
    in_valid = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_res",   32'(ALU_OUT), 32'd0);
    chk("abort_rem",   32'(REM_OUT), 32'd0);
    chk("abort_flags", 32'(flags_now()), 32'd0);
    cnt = 0;
    repeat (20) begin
      @(negedge CLK);
      if (out_valid) cnt++;
    end
    chk("abort_no_late", 32'(cnt), 32'd0);

    // 6: shift, compare, logic, default
    drive(OP_SHL,  16'h0003, 16'h0001);
    expect_out("shl",  16'h0006, 16'h0000, 7'b0001000);
    drive(OP_SHR,  16'h8000, 16'h000F);
    expect_out("shr",  16'h0001, 16'h0000, 7'b0001000);
    drive(OP_GT,   16'h0007, 16'h0001);
    expect_out("gt",   16'h0002, 16'h0000, 7'b0010000);
    drive(OP_LT,   16'hFFFF, 16'h0001);
    expect_out("lt_signed", 16'h0003, 16'h0000, 7'b0010000);
    drive(OP_GT,   16'h0001, 16'hFFFF);
    expect_out("gt_signed", 16'h0002, 16'h0000, 7'b0010000);
    drive(OP_EQ,   16'h0005, 16'h0006);
    expect_out("eq_false",  16'h0000, 16'h0000, 7'b0010010);
    drive(OP_AND,  16'hF0F0, 16'h0FF0);
    expect_out("and",  16'h00F0, 16'h0000, 7'b0100000);
    drive(OP_XNOR, 16'h0003, 16'h000D);
    expect_out("xnor", 16'hFFF1, 16'h0000, 7'b0100000);
    drive(OP_DEF,  16'h1234, 16'h5678);
    expect_out("opf",  16'h0000, 16'h0000, 7'b0000010);
    in_valid = 1'b0;
    @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_pipe_param.md
Name: alu_pipe_param

Overview:
Parametrised successor to the 16-bit ALU, with a valid/ready input handshake, registered results and status flags. All operations except divide complete in 1 cycle. Divide runs as a WIDTH-cycle iterative restoring divider and also returns the remainder. The block is the datapath execution unit between the operand/opcode issue logic and the result writeback stage.

Parameters:
WIDTH, 16, operand/result width in bits (>=4)
SHW, $clog2(WIDTH), shift-amount bits taken from B
SIGNED_CMP, 0, 1 = EQ/GT/LT compare as two's complement; 0 = unsigned

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
in_valid  in  1  operand/opcode valid
in_ready  out  1  block can accept (high when not dividing)
A  in  WIDTH  operand A
B  in  WIDTH  operand B
ALU_FUN  in  4  opcode
out_valid  out  1  one-cycle pulse: ALU_OUT/REM_OUT/flags updated
ALU_OUT  out  WIDTH  result
REM_OUT  out  WIDTH  DIV remainder (0 for other ops)
Arith_Flag  out  1  result came from ADD/SUB/MUL/DIV
Logic_Flag  out  1  result came from AND..XNOR
CMP_Flag  out  1  result came from EQ/GT/LT
Shift_Flag  out  1  result came from SHR/SHL
Carry_Flag  out  1  ADD carry-out / SUB borrow / MUL high half nonzero
Zero_Flag  out  1  ALU_OUT == 0
DivZ_Flag  out  1  DIV with B == 0

Behaviour:
- Reset: every output 0 except in_ready = 1. State goes to IDLE. Any divide in flight is abandoned and produces no late out_valid.
- Accept: in_valid && in_ready at a rising edge. in_valid while in_ready = 0 is ignored; no queueing.
- Opcodes:
  - 0 ADD, 1 SUB, 2 MUL (low WIDTH bits), 3 DIV
  - 4 AND, 5 OR, 6 NAND, 7 NOR, 8 XOR, 9 XNOR
  - A EQ (out 1 if true), B GT (out 2 if true), C LT (out 3 if true); a false compare gives 0
  - D SHR (A >> B[SHW-1:0], logical), E SHL (A << B[SHW-1:0])
  - F: result 0, all class flags 0
- Single-cycle ops: on the accept edge, ALU_OUT, REM_OUT, and all flags are registered and out_valid = 1 for one cycle. in_ready stays 1, so back-to-back issue every cycle is allowed.
- Class flags are one-hot, or all 0 for F. Carry_Flag is 0 for non-arithmetic ops and for DIV. Zero_Flag is computed on the registered ALU_OUT value.
- Outputs hold their last value between out_valid pulses.
- FSM states: IDLE, DIV_BUSY.
  - IDLE -> DIV_BUSY on accept of DIV with B != 0. Divider loads A and B and the iteration counter is cleared.
  - DIV_BUSY: one quotient bit per cycle, MSB first; in_ready = 0.
  - After WIDTH iterations: ALU_OUT = quotient, REM_OUT = remainder, Arith_Flag = 1, out_valid = 1, state = IDLE, in_ready = 1 in that same cycle.
  - Latency: out_valid is asserted in the WIDTH-th cycle after the accept edge; in_ready is low for exactly WIDTH cycles.
- DIV with B == 0: no BUSY state, single-cycle. ALU_OUT = all ones, REM_OUT = A, DivZ_Flag = 1, Arith_Flag = 1.
- RST has priority over accept and over the divider iteration in the same cycle.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD..OP_DEF)
  - FSM state encoding
  - a flag-bundle struct/constant width.
- One sub-module, alu_divider. It takes WIDTH, start, A and B, and returns done, quotient and remainder; reset is synchronous.
- The parent owns the handshake, the combinational op mux, and the output registers.

Test Plan:
1. RST 2 cycles, then ADD A=0x0003 B=0x000D -> next cycle: out_valid=1, ALU_OUT=0x0010, Arith_Flag=1, Carry_Flag=0, Zero_Flag=0.
2. ADD 0xFFFF+0x0001, then SUB 0x0002-0x0003 on back-to-back cycles -> ALU_OUT=0x0000 with Carry=1, Zero=1; then ALU_OUT=0xFFFF with Carry=1; in_ready stays 1 throughout.
3. DIV A=100 B=7 -> in_ready low 16 cycles; out_valid in 16th cycle after accept; ALU_OUT=14, REM_OUT=2. A second in_valid issued during BUSY is ignored.
4. DIV A=0x1234 B=0 -> next cycle: ALU_OUT=0xFFFF, REM_OUT=0x1234, DivZ_Flag=1, in_ready never drops.
5. DIV A=100 B=7, assert RST 5 cycles after accept -> the following cycle in_ready=1, all outputs 0; no out_valid within the next 20 cycles.
6. Issue in sequence:
   - SHL A=3 B=1 -> 6, Shift_Flag=1
   - SHR A=0x8000 B=15 -> 1
   - GT A=7 B=1 -> 2, CMP_Flag=1
   - LT A=0xFFFF B=1 with SIGNED_CMP=1 -> 3
   - XNOR A=3 B=0xD -> 0xFFF1, Logic_Flag=1
   - op F -> 0, all class flags 0
